// File: rtl/cordic_pkg.sv
// Constants and FSM state shared by the hyperbolic CORDIC stages and the tanh divider.
package cordic_pkg;

    localparam int W    = 21;
    localparam int FRAC = 16;

    localparam logic [W-1:0] ONE_Q    = 21'h10000;
    localparam logic [W-1:0] TANH_MAX = 21'h0FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_udiv.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// ovf flags a quotient that does not fit in Q_W bits (including den == 0).
module seq_udiv #(
    parameter int NUM_W = 37,
    parameter int DEN_W = 21,
    parameter int Q_W   = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [Q_W-1:0]   quo
);

    localparam int RW = DEN_W + 1;
    localparam int CW = $clog2(Q_W);

    logic [RW-1:0]    rem_q, rem_d;
    logic [Q_W-1:0]   low_q, low_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic [RW-1:0] num_hi;
    logic [RW:0]   trial;
    logic [RW:0]   trial_sub;

    assign num_hi    = RW'(num[NUM_W-1:Q_W]);
    assign trial     = {rem_q, low_q[Q_W-1]};
    assign trial_sub = trial - (RW+1)'(den_q);

    // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rem_d  = rem_q;
        low_d  = low_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        if (start && !busy_q) begin
            // High part of the numerator seeds the remainder; low bits shift in one per step.
            rem_d  = num_hi;
            low_d  = num[Q_W-1:0];
            den_d  = den;
            cnt_d  = CW'(Q_W - 1);
            busy_d = 1'b1;
            ovf_d  = (num_hi >= RW'(den));
        end else if (busy_q) begin
            // low_q doubles as the quotient register: numerator bits leave at the top, quotient bits enter at the bottom.
            if (trial >= (RW+1)'(den_q)) begin
                rem_d = trial_sub[RW-1:0];
                low_d = {low_q[Q_W-2:0], 1'b1};
            end else begin
                rem_d = trial[RW-1:0];
                low_d = {low_q[Q_W-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q  <= '0;
            low_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            low_q  <= low_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign quo  = low_q;

endmodule

// File: rtl/cordic_tanh_div.sv
// tanh = sinh/cosh in signed Q5.16 with valid/ready on both sides and saturation below 1.0.
// Optional exp_out = cosh + sinh when CORDIC_TANH_EXP_OUT_EN is defined.
module cordic_tanh_div
    import cordic_pkg::*;
#(
    parameter int W    = cordic_pkg::W,
    parameter int FRAC = cordic_pkg::FRAC
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] cosh_in,
    input  logic [W-1:0] sinh_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] tanh_out,
    output logic         tanh_sat
`ifdef CORDIC_TANH_EXP_OUT_EN
    ,
    output logic [W-1:0] exp_out
`endif
);

    localparam logic [W-1:0] TANH_MAX_W = W'((1 << FRAC) - 1);

    state_t       state_q, state_d;
    logic         sign_q, sign_d;
    logic [W-1:0] tanh_q, tanh_d;
    logic         sat_q, sat_d;

    logic           accept;
    logic [W-1:0]   sinh_mag;
    logic [W-1:0]   res_mag;
    logic           res_sat;
    logic           div_busy;
    logic           div_done;
    logic           div_ovf;
    logic [FRAC:0]  div_quo;

    assign accept   = in_valid && (state_q == IDLE);
    // Two's-complement abs: the most negative code maps to its own unsigned magnitude.
    assign sinh_mag = sinh_in[W-1] ? (~sinh_in + W'(1)) : sinh_in;

    seq_udiv #(
        .NUM_W (W + FRAC),
        .DEN_W (W),
        .Q_W   (FRAC + 1)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .num   ({sinh_mag, {FRAC{1'b0}}}),
        .den   (cosh_in),
        .busy  (div_busy),
        .done  (div_done),
        .ovf   (div_ovf),
        .quo   (div_quo)
    );

    // Divider overflow also covers cosh == 0, since any remainder compares >= 0.
    assign res_sat = div_ovf || div_quo[FRAC];
    assign res_mag = res_sat ? TANH_MAX_W : W'(div_quo);

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        tanh_d  = tanh_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = DIV;
                    sign_d  = sinh_in[W-1];
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = DONE;
                    sat_d   = res_sat;
                    tanh_d  = sign_q ? (W'(0) - res_mag) : res_mag;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: every register, including the datapath, is cleared by the async reset so a mid-divide abort leaves nothing stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            tanh_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            tanh_q  <= tanh_d;
            sat_q   <= sat_d;
        end
    end

`ifdef CORDIC_TANH_EXP_OUT_EN
    logic [W-1:0] exp_q, exp_d;

    always_comb begin
        exp_d = exp_q;
        if (accept) exp_d = cosh_in + sinh_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) exp_q <= '0;
        else     exp_q <= exp_d;
    end

    assign exp_out = exp_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign tanh_out  = tanh_q;
    assign tanh_sat  = sat_q;

endmodule

// File: tb/tb_cordic_tanh_div.sv
// Directed self-checking bench for cordic_tanh_div; checks exp_out too when CORDIC_TANH_EXP_OUT_EN is defined.
module tb_cordic_tanh_div;

    localparam int W = 21;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] cosh_in;
    logic [W-1:0] sinh_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] tanh_out;
    logic         tanh_sat;
`ifdef CORDIC_TANH_EXP_OUT_EN
    logic [W-1:0] exp_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cordic_tanh_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cosh_in   (cosh_in),
        .sinh_in   (sinh_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tanh_out  (tanh_out),
        .tanh_sat  (tanh_sat)
`ifdef CORDIC_TANH_EXP_OUT_EN
        ,
        .exp_out   (exp_out)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for out_valid; returns edges counted since the accept edge.
    task automatic wait_out(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!out_valid && cycles < 100);
    endtask

    // Present a pair at the negedge; accepted at the following posedge (block must be idle).
    task automatic send(input logic [W-1:0] c, input logic [W-1:0] s);
        @(negedge clk);
        check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
        cosh_in  = c;
        sinh_in  = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_drain", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] c, input logic [W-1:0] s,
                           input logic [W-1:0] exp_tanh, input logic exp_sat);
        int cyc;
        send(c, s);
        wait_out(cyc);
        check({tag, "_latency"}, cyc, 32'd18);
        check({tag, "_tanh"}, {11'd0, tanh_out}, {11'd0, exp_tanh});
        check({tag, "_sat"}, {31'd0, tanh_sat}, {31'd0, exp_sat});
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  cyc;
        logic spurious;
        logic [W-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cosh_in   = '0;
        sinh_in   = '0;
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_tanh", {11'd0, tanh_out}, 32'd0);
        check("reset_sat", {31'd0, tanh_sat}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_vec("zero",      21'h10000, 21'h00000, 21'h00000, 1'b0);
        run_vec("tanh1",     21'h18B07, 21'h12CDA, 21'h0C2F8, 1'b0);
`ifdef CORDIC_TANH_EXP_OUT_EN
        check("exp_out_e", {11'd0, exp_out}, 32'h2B7E1);
`endif
        run_vec("tanh1_neg", 21'h18B07, 21'h1ED326, 21'h1F3D08, 1'b0);
        run_vec("sat_one",   21'h10000, 21'h10000, 21'h0FFFF, 1'b1);
        run_vec("sat_den0",  21'h00000, 21'h05000, 21'h0FFFF, 1'b1);
        run_vec("sat_neg",   21'h10000, 21'h1F0000, 21'h1F0001, 1'b1);
        run_vec("min_code",  21'h00000, 21'h100000, 21'h1F0001, 1'b1);

        // Backpressure: result held while out_ready is low and a second pair waits.
        send(21'h18B07, 21'h12CDA);
        wait_out(cyc);
        check("bp_latency", cyc, 32'd18);
        held = tanh_out;
        check("bp_first_tanh", {11'd0, held}, 32'h0C2F8);
        @(negedge clk);
        cosh_in  = 21'h10000;
        sinh_in  = 21'h08000;
        in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bp_tanh_stable", {11'd0, tanh_out}, {11'd0, held});
        check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_after_hs", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
        wait_out(cyc);
        check("bp_second_latency", cyc, 32'd18);
        check("bp_second_tanh", {11'd0, tanh_out}, 32'h08000);
        check("bp_second_sat", {31'd0, tanh_sat}, 32'd0);
        drain();

        // Reset in the middle of a divide aborts it with no result.
        send(21'h18B07, 21'h12CDA);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_tanh", {11'd0, tanh_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spurious = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) spurious = 1'b1;
        end
        check("midrst_no_result", {31'd0, spurious}, 32'd0);

        run_vec("after_rst", 21'h10000, 21'h1F8000, 21'h1F8000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
